// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one aligned fetch per cycle to a 1-cycle sync
// instruction memory and buffers returned words for decode behind a valid/ready handshake.
module instr_fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [63:0]      pc;
    logic [63:0]      req_pc;
    logic             inflight;
    logic [63:0]      buf_pc    [BUF_DEPTH];
    logic [31:0]      buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occupancy;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign imem_addr = pc;
    assign if_valid  = (count != '0);
    assign if_pc     = if_valid ? buf_pc[rd_ptr]    : '0;
    assign if_instr  = if_valid ? buf_instr[rd_ptr] : '0;

    // Credit check: entries held plus the response on its way, less the one leaving now,
    // must leave a free slot, so a response always finds room when it arrives.
    always_comb begin
        pop       = if_valid & if_ready;
        push      = inflight & ~redirect_valid;
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        issue     = fetch_en & ~redirect_valid & (occupancy < (CNT_W + 1)'(BUF_DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~64'h3;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + 64'd4;
            end
            inflight <= issue;
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: buffer storage is deliberately not reset; outputs are gated by count, so
    // stale contents are never visible and the array can map to plain flops or RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= req_pc;
            buf_instr[wr_ptr] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level queue model of the fetch path.
module tb_instr_fetch_ctrl;

    localparam int          DEPTH = 2;
    localparam logic [63:0] RST_PC = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    int total = 0;
    int bad   = 0;

    beat_t       m_buf[$];
    logic [63:0] m_pend[$];
    logic [63:0] m_pc;

    instr_fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] addr);
        case (addr)
            64'h0:   return 32'h11223344;
            64'h4:   return 32'hAABBCCDD;
            64'h8:   return 32'hFEDCBA98;
            default: return addr[31:0] ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Synchronous-read instruction memory, one cycle of latency.
    always @(posedge clk) imem_instr <= word_at(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_pend.delete();
        m_pc = RST_PC;
    endtask

    task automatic check_outputs();
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        e_valid = (m_buf.size() > 0);
        e_pc    = e_valid ? m_buf[0].pc    : 64'h0;
        e_instr = e_valid ? m_buf[0].instr : 32'h0;
        check("if_valid",  {63'h0, if_valid}, {63'h0, e_valid});
        check("if_pc",     if_pc, e_pc);
        check("if_instr",  {32'h0, if_instr}, {32'h0, e_instr});
        check("imem_addr", imem_addr, m_pc);
    endtask

    // Called at a falling edge: check, drive, take the rising edge, advance the model.
    task automatic cycle(input logic fe, input logic rv, input logic [63:0] rpc, input logic rdy);
        bit pop;
        bit issue;
        check_outputs();
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        @(posedge clk);
        pop = (m_buf.size() > 0) && rdy;
        if (rv) begin
            m_buf.delete();
            m_pend.delete();
            m_pc = {rpc[63:2], 2'b00};
        end else begin
            issue = fe && ((m_buf.size() + m_pend.size() - int'(pop)) < DEPTH);
            if (pop) void'(m_buf.pop_front());
            if (m_pend.size() > 0) m_buf.push_back('{pc: m_pend[0], instr: word_at(m_pend[0])});
            m_pend.delete();
            if (issue) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] held_addr;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Startup: first beat visible after the second edge, then back-to-back.
        cycle(1, 0, 0, 1);
        check("start_not_valid", {63'h0, if_valid}, 64'h0);
        cycle(1, 0, 0, 1);
        check("beat0_pc", if_pc, 64'h0);
        check("beat0_instr", {32'h0, if_instr}, 64'h11223344);
        cycle(1, 0, 0, 1);
        check("beat1_pc", if_pc, 64'h4);
        cycle(1, 0, 0, 1);
        check("beat2_instr", {32'h0, if_instr}, 64'hFEDCBA98);

        // Decode stall, then release.
        repeat (5) cycle(1, 0, 0, 0);
        repeat (4) cycle(1, 0, 0, 1);

        // Misaligned redirect while streaming.
        cycle(1, 1, 64'h6, 1);
        check("redir_flush", {63'h0, if_valid}, 64'h0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("redir_pc", if_pc, 64'h4);
        check("redir_instr", {32'h0, if_instr}, 64'hAABBCCDD);

        // Fetch disabled mid-stream: buffer drains, address freezes.
        repeat (4) cycle(1, 0, 0, 1);
        repeat (DEPTH + 1) cycle(0, 0, 0, 1);
        held_addr = imem_addr;
        repeat (3) cycle(0, 0, 0, 1);
        check("drain_empty", {63'h0, if_valid}, 64'h0);
        check("addr_frozen", imem_addr, held_addr);

        // Redirect coinciding with a pop and a pending response.
        repeat (3) cycle(1, 0, 0, 1);
        cycle(1, 1, 64'h8, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("redir2_pc", if_pc, 64'h8);
        check("redir2_instr", {32'h0, if_instr}, 64'hFEDCBA98);

        // Asynchronous reset between edges.
        repeat (3) cycle(1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {63'h0, if_valid}, 64'h0);
        check("rst_pc", if_pc, 64'h0);
        check("rst_instr", {32'h0, if_instr}, 64'h0);
        check("rst_addr", imem_addr, RST_PC);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cycle(1, 0, 0, 1);
        check("restart_pc", if_pc, 64'h0);

        // Randomized traffic including back-to-back redirects.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 15) == 0,
                  64'($urandom_range(0, 63)),
                  $urandom_range(0, 3) != 0);
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
